// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one synchronous RAM between
// instruction fetch, data port and the UART loader, with loader exclusivity.
module ram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  input  logic                m2_req,
  input  logic                m2_we,
  input  logic [ADDR_W-1:0]   m2_addr,
  input  logic [DATA_W-1:0]   m2_wdata,
  input  logic [DATA_W/8-1:0] m2_wstrb,
  output logic                m2_gnt,
  output logic                m2_rvalid,
  output logic [DATA_W-1:0]   m2_rdata,
  input  logic                m2_excl,
  output logic                core_stall,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [ADDR_W-3:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int SW = DATA_W / 8;

  typedef enum logic [1:0] {
    SHARED = 2'd0,
    DRAIN  = 2'd1,
    EXCL   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [1:0] rr_q, rr_d;
  logic       stall_q, stall_d;

  logic [RAM_LAT-1:0]      pv_q, pv_d;
  logic [RAM_LAT-1:0][1:0] pid_q, pid_d;

  logic [2:0] req;
  logic [2:0] elig;
  logic [1:0] p1, p2;
  logic [1:0] win;
  logic       win_vld;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [SW-1:0]     sel_wstrb;

  logic       rv;
  logic [1:0] rid;
  logic       pipe_empty;
  logic       unused_lsbs;

  assign unused_lsbs = ^sel_addr[1:0];
  assign core_stall  = stall_q;

  // Mode decides who may compete; first eligible at or after rr_q wins.
  always_comb begin
    req  = {m2_req, m1_req, m0_req};
    elig = 3'b000;
    unique case (state_q)
      SHARED:  elig = m2_excl ? 3'b000 : req;
      DRAIN:   elig = 3'b000;
      EXCL:    elig = {m2_req, 2'b00};
      default: elig = 3'b000;
    endcase
    if (!rst_n) begin
      elig = 3'b000;
    end
    p1      = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
    p2      = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
    win_vld = |elig;
    win     = 2'd0;
    if (elig[rr_q]) begin
      win = rr_q;
    end else if (elig[p1]) begin
      win = p1;
    end else if (elig[p2]) begin
      win = p2;
    end
  end

  // Route the winner's fields to the RAM and raise its grant.
  always_comb begin
    sel_we    = m0_we;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    sel_wstrb = m0_wstrb;
    unique case (win)
      2'd1: begin
        sel_we    = m1_we;
        sel_addr  = m1_addr;
        sel_wdata = m1_wdata;
        sel_wstrb = m1_wstrb;
      end
      2'd2: begin
        sel_we    = m2_we;
        sel_addr  = m2_addr;
        sel_wdata = m2_wdata;
        sel_wstrb = m2_wstrb;
      end
      default: begin
        sel_we    = m0_we;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        sel_wstrb = m0_wstrb;
      end
    endcase
    m0_gnt    = win_vld && (win == 2'd0);
    m1_gnt    = win_vld && (win == 2'd1);
    m2_gnt    = win_vld && (win == 2'd2);
    ram_en    = win_vld;
    ram_we    = (win_vld && sel_we) ? sel_wstrb : '0;
    ram_addr  = win_vld ? sel_addr[ADDR_W-1:2] : '0;
    ram_wdata = win_vld ? sel_wdata : '0;
  end

  // Owner pipeline: each granted read enters at stage 0 tagged with its id.
  always_comb begin
    pv_d     = '0;
    pid_d    = '0;
    pv_d[0]  = win_vld && !sel_we;
    pid_d[0] = win;
    for (int i = 1; i < RAM_LAT; i++) begin
      pv_d[i]  = pv_q[i-1];
      pid_d[i] = pid_q[i-1];
    end
  end

  // Last stage steers RAM data to its owner; others see zero.
  always_comb begin
    rv         = pv_q[RAM_LAT-1];
    rid        = pid_q[RAM_LAT-1];
    pipe_empty = ~|pv_q;
    m0_rvalid  = rv && (rid == 2'd0);
    m1_rvalid  = rv && (rid == 2'd1);
    m2_rvalid  = rv && (rid == 2'd2);
    m0_rdata   = m0_rvalid ? ram_rdata : '0;
    m1_rdata   = m1_rvalid ? ram_rdata : '0;
    m2_rdata   = m2_rvalid ? ram_rdata : '0;
  end

  // Mode sequencing, stall from next mode, pointer follows the winner.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SHARED: begin
        if (m2_excl) state_d = DRAIN;
      end
      DRAIN: begin
        if (!m2_excl) begin
          state_d = SHARED;
        end else if (pipe_empty) begin
          state_d = EXCL;
        end
      end
      EXCL: begin
        if (!m2_excl && pipe_empty) state_d = SHARED;
      end
      default: state_d = SHARED;
    endcase
    stall_d = (state_d != SHARED);
    rr_d    = rr_q;
    if (win_vld) begin
      rr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
    end
  end

  // State registers; reset flushes any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SHARED;
      rr_q    <= 2'd0;
      stall_q <= 1'b0;
      pv_q    <= '0;
      pid_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      stall_q <= stall_d;
      pv_q    <= pv_d;
      pid_q   <= pid_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: random and directed traffic against a behavioural
// arbiter/RAM model, with a per-master scoreboard for read returns.
module tb_ram_arbiter;

  localparam int LAT = 3;

  typedef struct {
    int          arr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [2:0]  we = 3'b000;
  logic        excl = 1'b0;
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [3:0]  wstrb [3];
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [31:0] rdata [3];
  logic        core_stall;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int   mode = 0;
  int   ptr = 0;
  int   inflight [$];
  logic [31:0] shadow [256];
  exp_t sb [3][$];

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]),
    .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_gnt(gnt[0]),
    .m0_rvalid(rvalid[0]), .m0_rdata(rdata[0]),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]),
    .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_gnt(gnt[1]),
    .m1_rvalid(rvalid[1]), .m1_rdata(rdata[1]),
    .m2_req(req[2]), .m2_we(we[2]), .m2_addr(addr[2]),
    .m2_wdata(wdata[2]), .m2_wstrb(wstrb[2]), .m2_gnt(gnt[2]),
    .m2_rvalid(rvalid[2]), .m2_rdata(rdata[2]),
    .m2_excl(excl), .core_stall(core_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    return (i == 0) ? 32'h0000_0013 : (32'h5A00_0000 | 32'(i));
  endfunction

  // Environment RAM: written and sampled at the clock edge of ram_en.
  bit          written [256];
  logic [31:0] mem [256];
  logic [31:0] rpipe [LAT];
  logic [31:0] ram_cur, ram_merged;

  always_comb begin
    ram_cur = written[ram_addr[7:0]] ? mem[ram_addr[7:0]]
                                     : init_word(int'(ram_addr[7:0]));
    ram_merged = ram_cur;
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) ram_merged[8*b +: 8] = ram_wdata[8*b +: 8];
  end

  always @(posedge clk) begin
    if (ram_en && ram_we != 4'h0) begin
      mem[ram_addr[7:0]]     <= ram_merged;
      written[ram_addr[7:0]] <= 1'b1;
    end
    rpipe[0] <= ram_cur;
    for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
  end

  assign ram_rdata = rpipe[LAT-1];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: any read return must match the head of that master's queue.
  always @(negedge clk) begin : mon
    exp_t e;
    bit   due;
    for (int i = 0; i < 3; i++) begin
      due = (sb[i].size() != 0) && (sb[i][0].arr == cyc);
      chk($sformatf("rvalid_m%0d", i), rvalid[i], due);
      if (due) begin
        e = sb[i].pop_front();
        if (rvalid[i]) chk($sformatf("rdata_m%0d", i), rdata[i], e.data);
      end else if (!rvalid[i]) begin
        chk($sformatf("rdata_idle_m%0d", i), rdata[i], 32'h0);
      end
    end
  end

  // Reference: eligibility by mode, rotating priority, shadow memory.
  task automatic evaluate(output logic [2:0] g);
    logic [2:0]  elig;
    int          w;
    int          wi;
    bit          empty;
    logic [31:0] v;
    exp_t        e;
    while (inflight.size() != 0 && inflight[0] < cyc)
      void'(inflight.pop_front());
    empty = (inflight.size() == 0);
    if (mode == 0) elig = excl ? 3'b000 : req;
    else if (mode == 1) elig = 3'b000;
    else elig = req & 3'b100;
    w = -1;
    for (int k = 0; k < 3; k++)
      if (w < 0 && elig[(ptr + k) % 3]) w = (ptr + k) % 3;
    g = (w < 0) ? 3'b000 : 3'(1 << w);
    chk("gnt", gnt, g);
    chk("core_stall", core_stall, mode != 0);
    chk("ram_en", ram_en, w >= 0);
    if (w >= 0) begin
      wi = int'(addr[w][9:2]);
      chk("ram_addr", ram_addr, addr[w][31:2]);
      if (we[w]) begin
        chk("ram_we", ram_we, wstrb[w]);
        chk("ram_wdata", ram_wdata, wdata[w]);
        v = shadow[wi];
        for (int b = 0; b < 4; b++)
          if (wstrb[w][b]) v[8*b +: 8] = wdata[w][8*b +: 8];
        shadow[wi] = v;
      end else begin
        chk("ram_we_rd", ram_we, 4'h0);
        e.arr  = cyc + LAT;
        e.data = shadow[wi];
        sb[w].push_back(e);
        inflight.push_back(cyc + LAT);
      end
      ptr = (w + 1) % 3;
    end
    case (mode)
      0: if (excl) mode = 1;
      1: if (!excl) mode = 0; else if (empty) mode = 2;
      default: if (!excl && empty) mode = 0;
    endcase
  endtask

  task automatic tick();
    logic [2:0] g;
    @(negedge clk);
    evaluate(g);
    @(posedge clk);
    cyc++;
    #1;
    req = req & ~g;
  endtask

  task automatic issue(int i, bit w, int word, logic [31:0] d,
                       logic [3:0] s);
    if (!req[i]) begin
      we[i]    = w;
      addr[i]  = 32'h8000_0000 + 32'(word) * 4;
      wdata[i] = d;
      wstrb[i] = s;
      req[i]   = 1'b1;
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_rvalid", rvalid, 3'b000);
    chk("rst_stall", core_stall, 1'b0);
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_ram_we", ram_we, 4'h0);
    chk("rst_ram_addr", ram_addr, 30'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_rdata", rdata[0] | rdata[1] | rdata[2], 32'h0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) sb[i].delete();
    inflight.delete();
    mode = 0;
    ptr  = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    for (int i = 0; i < 3; i++) begin
      addr[i]  = 32'h8000_0000;
      wdata[i] = 32'h1234_5678;
      wstrb[i] = 4'hF;
    end
    req = 3'b111;
    #2;
    chk_reset_outputs();
    @(posedge clk);
    cyc++;
    @(posedge clk);
    cyc++;
    #1;
    req   = 3'b000;
    rst_n = 1'b1;

    // Solo read of the word preloaded with 0x13.
    issue(0, 0, 0, 32'h0, 4'h0);
    repeat (LAT + 2) tick();

    // All three streaming reads: rotating grant order.
    repeat (6) begin
      for (int i = 0; i < 3; i++)
        issue(i, 0, $urandom_range(255), 32'h0, 4'h0);
      tick();
    end
    repeat (LAT + 1) tick();

    // Full write, readback, byte write, readback.
    issue(1, 1, 'h40, 32'hDEAD_BEEF, 4'hF);
    tick();
    issue(1, 0, 'h40, 32'h0, 4'h0);
    tick();
    issue(1, 1, 'h40, 32'h0000_00AA, 4'h1);
    tick();
    issue(1, 0, 'h40, 32'h0, 4'h0);
    repeat (LAT + 2) tick();

    // Exclusive entry with a read still in flight.
    issue(0, 0, 3, 32'h0, 4'h0);
    tick();
    excl = 1'b1;
    issue(1, 0, 7, 32'h0, 4'h0);
    repeat (10) begin
      issue(2, 0, $urandom_range(255), 32'h0, 4'h0);
      tick();
    end

    // Exclusive exit; the held m1 read must then win.
    repeat (LAT + 1) tick();
    excl = 1'b0;
    repeat (LAT + 4) tick();

    // Random traffic with exclusivity toggling.
    repeat (3000) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(3) == 0)
          issue(i, 1'($urandom_range(1)), $urandom_range(15), $urandom,
                4'($urandom_range(15, 1)));
      if ($urandom_range(29) == 0) excl = ~excl;
      tick();
    end

    // Reset while an m1 read is in flight.
    excl = 1'b0;
    repeat (LAT + 12) tick();
    issue(1, 0, 9, 32'h0, 4'h0);
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) issue(i, 0, i + 20, 32'h0, 4'h0);
    #1;
    chk_reset_outputs();
    model_reset();
    @(posedge clk);
    cyc++;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    repeat (LAT + 4) tick();

    // Drain and confirm every expected read came back.
    repeat (20) tick();
    chk("sb_drained", 64'(sb[0].size() + sb[1].size() + sb[2].size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the SoC's single-port synchronous RAM between three requesters: core instruction fetch (m0), core data port (m1) and the UART program loader (m2).
- Round-robin arbitration, at most one RAM access issued per cycle; read data is routed back to the owner after a fixed RAM latency.
- Exclusive mode lets the UART loader drain outstanding traffic and then own the RAM while the core is stalled. This is how images are loaded at run time instead of via $readmemh.

Parameters:
- ADDR_W, 32, byte address width; RAM word index is addr[ADDR_W-1:2].
- DATA_W, 32, data width; strobe width is DATA_W/8.
- RAM_LAT, 1, RAM read latency in cycles (1..4).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mX_req  in  1  request, X in {0,1,2}
- mX_we  in  1  1 = write, 0 = read
- mX_addr  in  ADDR_W  byte address
- mX_wdata  in  DATA_W  write data
- mX_wstrb  in  DATA_W/8  byte enables for writes
- mX_gnt  out  1  request accepted this cycle
- mX_rvalid  out  1  read data valid
- mX_rdata  out  DATA_W  read data
- m2_excl  in  1  loader requests exclusive ownership
- core_stall  out  1  core must freeze pc and issue no requests
- ram_en  out  1  RAM access strobe
- ram_we  out  DATA_W/8  byte write enables (0 for reads)
- ram_addr  out  ADDR_W-2  word address
- ram_wdata  out  DATA_W  write data
- ram_rdata  in  DATA_W  RAM read data, RAM_LAT cycles after ram_en

Behaviour:
- Reset (async, rst_n=0): state=SHARED; rr_ptr=0; owner pipeline cleared. All gnt, rvalid, ram_en, ram_we and core_stall are 0; rdata, ram_addr and ram_wdata are 0.
- Request handshake:
  - A request is held with stable fields until gnt.
  - gnt is combinational, in the same cycle as req.
  - ram_en, ram_we, ram_addr and ram_wdata are driven combinationally from the winner that cycle.
- Arbitration: among eligible requesters, the first at or after rr_ptr (mod 3) wins. After a grant, rr_ptr <= winner+1 (mod 3). With no grant, rr_ptr holds.
- Eligibility:
  - SHARED: m0, m1, m2.
  - DRAIN: none.
  - EXCL: m2 only.
- Read return:
  - A RAM_LAT-deep shift register carries {valid, owner id} for each granted read.
  - At depth RAM_LAT: owner's rvalid=1 for exactly 1 cycle, with rdata=ram_rdata.
  - Non-owner rdata = 0.
  - Writes produce no rvalid.
- Back-to-back: a new grant is allowed every cycle; reads and writes interleave freely. Write-then-read to the same address returns the new data (RAM write-first is not required; RAM is written at the grant edge).
- FSM:
  - SHARED -> DRAIN when m2_excl=1. No grant in the transition cycle.
  - DRAIN -> EXCL when the read pipeline is empty. DRAIN with an empty pipeline lasts 1 cycle.
  - EXCL -> SHARED when m2_excl=0 and the pipeline is empty.
  - DRAIN -> SHARED if m2_excl drops during DRAIN.
- core_stall = 1 in DRAIN and EXCL, registered from the next state, so it rises the cycle after m2_excl is sampled. Requests from m0/m1 while core_stall=1 are not granted and are not lost (the master keeps req high).
- Simultaneous: m2_excl rising with m0/m1/m2 requests pending -> no grant that cycle. Outstanding reads still return during DRAIN.
- rr_ptr is not modified by FSM transitions.
- Reset mid-transfer: the pipeline is flushed; in-flight rvalid is never delivered.

Test Plan:
1. Solo read: m0 reads 0x80000000 (RAM word holds 0x00000013), RAM_LAT=1 -> m0_gnt=1 in cycle t, ram_addr=0x20000000, m0_rvalid=1 and m0_rdata=0x00000013 at t+1; m1_rvalid and m2_rvalid stay 0.
2. Round-robin: m0, m1 and m2 request reads continuously from rr_ptr=0 -> grant order m0, m1, m2, m0, m1, m2 over 6 cycles; each rvalid lands on the correct master one cycle after its grant.
3. Write-then-read: m1 writes 0xDEADBEEF to 0x80000100 with wstrb=0xF, then reads it -> ram_we=0xF, then m1_rdata=0xDEADBEEF. Repeat with wstrb=0x1 and data 0x000000AA -> readback 0xDEADBEAA.
4. Exclusive entry with a read in flight (RAM_LAT=3): m0 read granted, m2_excl asserted next cycle -> no grants until the m0 rvalid has arrived; then state is EXCL and core_stall=1; held m1 req gets no gnt while m2 requests are granted every cycle.
5. Exclusive exit: deassert m2_excl in EXCL with an empty pipeline -> next cycle SHARED, core_stall=0, and a pending m1 request is granted.
6. Async reset mid-read: assert rst_n=0 between m1 grant and data return -> all outputs 0 immediately, no m1_rvalid after release, and the first post-reset grant goes to m0 when all three request.
